// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the common data bus among N_FU functional units.
// At most one grant per cycle; the winner's result is broadcast on cdb_* the following cycle.
module cdb_arbiter #(
    parameter int N_FU      = 4,
    parameter int ROB_IDX_W = 8,
    parameter int PREG_W    = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [N_FU-1:0]           req_valid,
    output logic [N_FU-1:0]           req_ready,
    input  logic [N_FU*ROB_IDX_W-1:0] req_rob_id,
    input  logic [N_FU*PREG_W-1:0]    req_pd,
    input  logic [N_FU*32-1:0]        req_data,
    output logic                      cdb_valid,
    output logic [ROB_IDX_W-1:0]      cdb_rob_id,
    output logic [PREG_W-1:0]         cdb_pd,
    output logic [31:0]               cdb_data,
    output logic [2:0]                cdb_fu_id
);

    localparam int PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1;

    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     rr_ptr_next;
    logic [2*N_FU-1:0]    req_wide;
    logic [N_FU-1:0]      req_rot;
    logic [N_FU-1:0]      pick_rot;
    logic [2*N_FU-1:0]    pick_wide;
    logic                 found;
    logic [N_FU-1:0]      grant;
    logic                 any_grant;
    logic [2:0]           winner;
    logic [ROB_IDX_W-1:0] win_rob_id;
    logic [PREG_W-1:0]    win_pd;
    logic [31:0]          win_data;

    // Rotate requests so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        req_wide = {req_valid, req_valid} >> rr_ptr;
        req_rot  = req_wide[N_FU-1:0];
        pick_rot = '0;
        found    = 1'b0;
        for (int unsigned j = 0; j < N_FU; j++) begin
            if (!found && req_rot[j]) begin
                pick_rot[j] = 1'b1;
                found       = 1'b1;
            end
        end
        pick_wide = {{N_FU{1'b0}}, pick_rot} << rr_ptr;
        grant     = (pick_wide[N_FU-1:0] | pick_wide[2*N_FU-1:N_FU])
                    & {N_FU{rst_n & ~flush}};
        any_grant = |grant;
    end

    always_comb begin
        winner     = '0;
        win_rob_id = '0;
        win_pd     = '0;
        win_data   = '0;
        for (int unsigned i = 0; i < N_FU; i++) begin
            if (grant[i]) begin
                winner     = 3'(i);
                win_rob_id = req_rob_id[i*ROB_IDX_W +: ROB_IDX_W];
                win_pd     = req_pd[i*PREG_W +: PREG_W];
                win_data   = req_data[i*32 +: 32];
            end
        end
    end

    always_comb begin
        if (flush) begin
            rr_ptr_next = '0;
        end else if (any_grant) begin
            rr_ptr_next = (winner == 3'(N_FU - 1)) ? '0 : PTR_W'(winner + 3'd1);
        end else begin
            rr_ptr_next = rr_ptr;
        end
    end

    assign req_ready = grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            cdb_valid  <= 1'b0;
            cdb_rob_id <= '0;
            cdb_pd     <= '0;
            cdb_data   <= '0;
            cdb_fu_id  <= '0;
        end else begin
            rr_ptr    <= rr_ptr_next;
            cdb_valid <= any_grant;
            if (any_grant) begin
                cdb_rob_id <= win_rob_id;
                cdb_pd     <= win_pd;
                cdb_data   <= win_data;
                cdb_fu_id  <= winner;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a round-robin reference model.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int RW = 8;
    localparam int PW = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*RW-1:0] req_rob_id;
    logic [N*PW-1:0] req_pd;
    logic [N*32-1:0] req_data;
    logic            cdb_valid;
    logic [RW-1:0]   cdb_rob_id;
    logic [PW-1:0]   cdb_pd;
    logic [31:0]     cdb_data;
    logic [2:0]      cdb_fu_id;

    logic [RW-1:0]   f_rob[N];
    logic [PW-1:0]   f_pd[N];
    logic [31:0]     f_data[N];

    int n_cmp = 0;
    int n_bad = 0;

    cdb_arbiter #(.N_FU(N), .ROB_IDX_W(RW), .PREG_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rob_id(req_rob_id), .req_pd(req_pd), .req_data(req_data),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_pd(cdb_pd),
        .cdb_data(cdb_data), .cdb_fu_id(cdb_fu_id)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_rob_id = '0;
        req_pd     = '0;
        req_data   = '0;
        for (int i = 0; i < N; i++) begin
            req_rob_id[i*RW +: RW] = f_rob[i];
            req_pd[i*PW +: PW]     = f_pd[i];
            req_data[i*32 +: 32]   = f_data[i];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: first requester at or after ptr, wrapping mod N; none while flushing.
    function automatic int pick(input logic [N-1:0] v, input int ptr, input logic fl);
        if (fl) return -1;
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    int            m_ptr = 0;
    int            m_last = -1;
    logic          e_valid = 1'b0;
    logic [RW-1:0] e_rob = '0;
    logic [PW-1:0] e_pd = '0;
    logic [31:0]   e_data = '0;
    int            e_fu = 0;

    always @(posedge clk or negedge rst_n) begin
        int g;
        if (!rst_n) begin
            m_ptr = 0; m_last = -1; e_valid = 1'b0;
            e_rob = '0; e_pd = '0; e_data = '0; e_fu = 0;
        end else begin
            g = pick(req_valid, m_ptr, flush);
            m_last = g;
            if (g >= 0) begin
                e_valid = 1'b1;
                e_rob   = f_rob[g];
                e_pd    = f_pd[g];
                e_data  = f_data[g];
                e_fu    = g;
                m_ptr   = (g + 1) % N;
            end else begin
                e_valid = 1'b0;
                if (flush) m_ptr = 0;
            end
        end
    end

    int dwait[N] = '{default: 0};

    always @(negedge clk) begin
        int g;
        int worst;
        logic [N-1:0] er;
        g  = rst_n ? pick(req_valid, m_ptr, flush) : -1;
        er = (g >= 0) ? (N'(1) << g) : '0;
        chk("req_ready", req_ready, er);
        chk("cdb_valid", cdb_valid, e_valid);
        chk("cdb_rob_id", cdb_rob_id, e_rob);
        chk("cdb_pd", cdb_pd, e_pd);
        chk("cdb_data", cdb_data, e_data);
        chk("cdb_fu_id", cdb_fu_id, 3'(e_fu));
        worst = 0;
        for (int i = 0; i < N; i++) begin
            if (rst_n && !flush && req_valid[i] && !req_ready[i]) dwait[i]++;
            else dwait[i] = 0;
            if (dwait[i] > worst) worst = dwait[i];
        end
        chk("fairness_wait_ok", (worst <= N - 1), 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fu(input int i, input logic v, input logic [RW-1:0] r,
                          input logic [PW-1:0] p, input logic [31:0] d);
        req_valid[i] = v;
        f_rob[i]     = r;
        f_pd[i]      = p;
        f_data[i]    = d;
    endtask

    initial begin
        for (int i = 0; i < N; i++) set_fu(i, 1'b0, '0, '0, '0);

        // Reset held for 3 cycles, then idle.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst cdb_valid", cdb_valid, 1'b0);
        chk("rst req_ready", req_ready, 4'b0000);
        chk("rst cdb_data", cdb_data, 32'h0);
        tick();

        // Single request from FU2.
        set_fu(2, 1'b1, 8'h05, 6'd17, 32'hDEADBEEF);
        @(negedge clk);
        chk("single ready", req_ready, 4'b0100);
        tick();
        req_valid[2] = 1'b0;
        chk("single valid", cdb_valid, 1'b1);
        chk("single rob", cdb_rob_id, 8'h05);
        chk("single pd", cdb_pd, 6'd17);
        chk("single data", cdb_data, 32'hDEADBEEF);
        chk("single fu", cdb_fu_id, 3'd2);

        // rr_ptr is now 3: FU3 beats FU0.
        set_fu(0, 1'b1, 8'h10, 6'd1, 32'h1000_0000);
        set_fu(3, 1'b1, 8'h13, 6'd4, 32'h1300_0000);
        @(negedge clk);
        chk("ptr3 ready", req_ready, 4'b1000);
        tick();
        req_valid[3] = 1'b0;
        chk("ptr3 fu", cdb_fu_id, 3'd3);
        @(negedge clk);
        chk("wrap ready", req_ready, 4'b0001);
        tick();
        req_valid[0] = 1'b0;
        chk("wrap fu", cdb_fu_id, 3'd0);
        set_fu(1, 1'b1, 8'h21, 6'd0, 32'h2100_0000);
        tick();
        req_valid[1] = 1'b0;

        // rr_ptr=2 with FU1 and FU3 requesting: 3 then 1.
        set_fu(1, 1'b1, 8'h31, 6'd9, 32'h3100_0000);
        set_fu(3, 1'b1, 8'h33, 6'd11, 32'h3300_0000);
        @(negedge clk);
        chk("p2 ready a", req_ready, 4'b1000);
        tick();
        req_valid[3] = 1'b0;
        chk("p2 fu a", cdb_fu_id, 3'd3);
        @(negedge clk);
        chk("p2 ready b", req_ready, 4'b0010);
        tick();
        req_valid[1] = 1'b0;
        chk("p2 fu b", cdb_fu_id, 3'd1);

        // Flush returns rr_ptr to 0, then all four request continuously.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < N; i++) set_fu(i, 1'b1, 8'(8'h40 + i), 6'(i + 2), 32'hA000_0000 + i);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("all ready", req_ready, N'(1) << (k % N));
            tick();
            chk("all fu", cdb_fu_id, 3'(k % N));
            chk("all valid", cdb_valid, 1'b1);
            f_data[k % N] = $urandom;
        end
        req_valid = '0;

        // Flush in the cycle after FU0's grant, FU1 waiting.
        set_fu(0, 1'b1, 8'h50, 6'd5, 32'h5000_0000);
        tick();
        req_valid[0] = 1'b0;
        set_fu(1, 1'b1, 8'h51, 6'd6, 32'h5100_0000);
        flush = 1'b1;
        chk("flush prior bcast", cdb_valid, 1'b1);
        @(negedge clk);
        chk("flush ready", req_ready, 4'b0000);
        tick();
        flush = 1'b0;
        chk("post flush valid", cdb_valid, 1'b0);
        @(negedge clk);
        chk("post flush ready", req_ready, 4'b0010);
        tick();
        req_valid[1] = 1'b0;
        chk("post flush fu", cdb_fu_id, 3'd1);

        // Idle gap after an FU0 grant; rr_ptr must stay 1.
        set_fu(0, 1'b1, 8'h60, 6'd0, 32'h6000_0000);
        tick();
        req_valid[0] = 1'b0;
        chk("gap pulse", cdb_valid, 1'b1);
        chk("gap pd0", cdb_pd, 6'd0);
        tick();
        chk("gap idle1", cdb_valid, 1'b0);
        tick();
        chk("gap idle2", cdb_valid, 1'b0);
        set_fu(0, 1'b1, 8'h70, 6'd7, 32'h7000_0000);
        set_fu(1, 1'b1, 8'h71, 6'd8, 32'h7100_0000);
        @(negedge clk);
        chk("gap ptr1 ready", req_ready, 4'b0010);
        tick();
        req_valid[1] = 1'b0;
        tick();
        req_valid[0] = 1'b0;

        // Asynchronous reset during a broadcast.
        set_fu(2, 1'b1, 8'h80, 6'd12, 32'h8000_0000);
        tick();
        req_valid[2] = 1'b0;
        req_valid[1] = 1'b1;
        #2;
        chk("mid bcast valid", cdb_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("areset valid", cdb_valid, 1'b0);
        chk("areset data", cdb_data, 32'h0);
        chk("areset fu", cdb_fu_id, 3'd0);
        chk("areset ready", req_ready, 4'b0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        req_valid = '0;

        // Randomized traffic obeying hold-until-transfer.
        repeat (3000) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (m_last == i) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 99) < 45) begin
                    set_fu(i, 1'b1, 8'($urandom), 6'($urandom), $urandom);
                end
            end
            flush = ($urandom_range(0, 99) < 4);
        end
        flush = 1'b0;
        req_valid = '0;
        tick();
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
